// File: rtl/alu_pkg.sv
// Shared types for the sequential ALU: opcode encoding and FSM states.
package alu_pkg;

  typedef enum logic [2:0] {
    OP_AND = 3'd0,
    OP_OR  = 3'd1,
    OP_XOR = 3'd2,
    OP_ADD = 3'd3,
    OP_SUB = 3'd4,
    OP_SHL = 3'd5,
    OP_SHR = 3'd6,
    OP_MUL = 3'd7
  } alu_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/alu_seq_unit_if.sv
// Request/response bundle of the sequential ALU.
//   master: start, A, B, select, cin out; busy, done, result, flags, seg in
//   slave : the mirror image, used by alu_seq_unit
interface alu_seq_unit_if #(
  parameter int unsigned N      = 8,
  parameter int unsigned DIGITS = N / 4
);

  logic                  start;
  logic [N-1:0]          A;
  logic [N-1:0]          B;
  logic [2:0]            select;
  logic                  cin;
  logic                  busy;
  logic                  done;
  logic [N-1:0]          result;
  logic                  cout;
  logic                  carry_flag;
  logic                  overflow;
  logic                  negative;
  logic                  zero;
  logic [7*DIGITS-1:0]   seg;

  modport master (
    output start, A, B, select, cin,
    input  busy, done, result, cout, carry_flag, overflow, negative, zero, seg
  );

  modport slave (
    input  start, A, B, select, cin,
    output busy, done, result, cout, carry_flag, overflow, negative, zero, seg
  );

endinterface

// File: rtl/hex_to_seg.sv
// Hex nibble to active-high seven-segment pattern, bit order a..g MSB to LSB.
//   nibble : 4-bit value to display
//   seg_c  : segment pattern {a,b,c,d,e,f,g}
module hex_to_seg (
  input  logic [3:0] nibble,
  output logic [6:0] seg_c
);

  always_comb begin
    seg_c = 7'h7E;
    case (nibble)
      4'h0: seg_c = 7'h7E;
      4'h1: seg_c = 7'h30;
      4'h2: seg_c = 7'h6D;
      4'h3: seg_c = 7'h79;
      4'h4: seg_c = 7'h33;
      4'h5: seg_c = 7'h5B;
      4'h6: seg_c = 7'h5F;
      4'h7: seg_c = 7'h70;
      4'h8: seg_c = 7'h7F;
      4'h9: seg_c = 7'h7B;
      4'hA: seg_c = 7'h77;
      4'hB: seg_c = 7'h1F;
      4'hC: seg_c = 7'h4E;
      4'hD: seg_c = 7'h3D;
      4'hE: seg_c = 7'h4F;
      4'hF: seg_c = 7'h47;
      default: seg_c = 7'h7E;
    endcase
  end

endmodule

// File: rtl/alu_seq_unit.sv
// Sequential ALU: logic/add/sub finish in one cycle, shifts take one bit per
// cycle, multiply is shift-add over N cycles. Result and flags are registered
// and shown in hex on DIGITS seven-segment digits.
//   clk, rst : clock, synchronous active-high reset
//   bus      : slave side of alu_seq_unit_if (request in, result/flags/seg out)
module alu_seq_unit
  import alu_pkg::*;
#(
  parameter int unsigned N      = 8,
  parameter int unsigned DIGITS = N / 4
) (
  input logic           clk,
  input logic           rst,
  alu_seq_unit_if.slave bus
);

  localparam int unsigned CW    = $clog2(N + 1);
  localparam logic [N-1:0] N_VAL = N'(N);

  state_e          state_q, state_n;
  alu_op_e         op_q, op_n, sel_c;
  logic [N-1:0]    acc_q, acc_n;
  logic [N-1:0]    mcand_q, mcand_n;
  logic [N-1:0]    mplier_q, mplier_n;
  logic [CW-1:0]   cnt_q, cnt_n, shamt_c;
  logic [N:0]      sum_c, diff_c;
  logic            wr_c, cout_c, ovf_c;
  logic [N-1:0]    res_c;

  logic [N-1:0]    result_q;
  logic            cout_q, carry_q, ovf_q, neg_q, zero_q, busy_q, done_q;
  logic [7*DIGITS-1:0] seg_c;

  // Single-cycle arithmetic on the live request; borrow-out lands in bit N.
  always_comb begin
    sel_c   = alu_op_e'(bus.select);
    sum_c   = {1'b0, bus.A} + {1'b0, bus.B} + {{N{1'b0}}, bus.cin};
    diff_c  = {1'b0, bus.A} - {1'b0, bus.B} - {{N{1'b0}}, bus.cin};
    shamt_c = CW'(bus.B % N_VAL);
  end

  // Next-state, datapath step and result write enable.
  always_comb begin
    state_n  = state_q;
    op_n     = op_q;
    acc_n    = acc_q;
    mcand_n  = mcand_q;
    mplier_n = mplier_q;
    cnt_n    = cnt_q;
    wr_c     = 1'b0;
    res_c    = '0;
    cout_c   = 1'b0;
    ovf_c    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          op_n    = sel_c;
          state_n = ST_DONE;
          case (sel_c)
            OP_AND: begin wr_c = 1'b1; res_c = bus.A & bus.B; end
            OP_OR:  begin wr_c = 1'b1; res_c = bus.A | bus.B; end
            OP_XOR: begin wr_c = 1'b1; res_c = bus.A ^ bus.B; end
            OP_ADD: begin
              wr_c   = 1'b1;
              res_c  = sum_c[N-1:0];
              cout_c = sum_c[N];
              ovf_c  = (bus.A[N-1] == bus.B[N-1]) && (sum_c[N-1] != bus.A[N-1]);
            end
            OP_SUB: begin
              wr_c   = 1'b1;
              res_c  = diff_c[N-1:0];
              cout_c = diff_c[N];
              ovf_c  = (bus.A[N-1] != bus.B[N-1]) && (diff_c[N-1] != bus.A[N-1]);
            end
            OP_SHL, OP_SHR: begin
              // Zero shift completes like a single-cycle op returning A.
              if (shamt_c == '0) begin
                wr_c  = 1'b1;
                res_c = bus.A;
              end else begin
                acc_n   = bus.A;
                cnt_n   = shamt_c;
                state_n = ST_EXEC;
              end
            end
            OP_MUL: begin
              acc_n    = '0;
              mcand_n  = bus.A;
              mplier_n = bus.B;
              cnt_n    = CW'(N);
              state_n  = ST_EXEC;
            end
            default: ;
          endcase
        end
      end
      ST_EXEC: begin
        cnt_n = cnt_q - CW'(1);
        case (op_q)
          OP_SHL: acc_n = acc_q << 1;
          OP_SHR: acc_n = acc_q >> 1;
          OP_MUL: begin
            acc_n    = acc_q + (mplier_q[0] ? mcand_q : '0);
            mcand_n  = mcand_q << 1;
            mplier_n = mplier_q >> 1;
          end
          default: ;
        endcase
        // Last step writes the freshly computed value straight to result.
        if (cnt_q == CW'(1)) begin
          wr_c    = 1'b1;
          res_c   = acc_n;
          state_n = ST_DONE;
        end
      end
      ST_DONE: state_n = ST_IDLE;
      default: state_n = ST_IDLE;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_n;
  end

  // Datapath, result and flag registers; busy/done follow the next state.
  always_ff @(posedge clk) begin
    if (rst) begin
      op_q     <= OP_AND;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
      result_q <= '0;
      cout_q   <= 1'b0;
      carry_q  <= 1'b0;
      ovf_q    <= 1'b0;
      neg_q    <= 1'b0;
      zero_q   <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      op_q     <= op_n;
      acc_q    <= acc_n;
      mcand_q  <= mcand_n;
      mplier_q <= mplier_n;
      cnt_q    <= cnt_n;
      busy_q   <= (state_n != ST_IDLE);
      done_q   <= (state_n == ST_DONE);
      if (wr_c) begin
        result_q <= res_c;
        cout_q   <= cout_c;
        carry_q  <= cout_c;
        ovf_q    <= ovf_c;
        neg_q    <= res_c[N-1];
        zero_q   <= (res_c == '0);
      end
    end
  end

  for (genvar k = 0; k < DIGITS; k++) begin : g_digit
    hex_to_seg u_hex (
      .nibble (result_q[4*k+3:4*k]),
      .seg_c  (seg_c[7*k+6:7*k])
    );
  end

  assign bus.seg        = seg_c;
  assign bus.result     = result_q;
  assign bus.cout       = cout_q;
  assign bus.carry_flag = carry_q;
  assign bus.overflow   = ovf_q;
  assign bus.negative   = neg_q;
  assign bus.zero       = zero_q;
  assign bus.busy       = busy_q;
  assign bus.done       = done_q;

endmodule

// File: tb/tb_alu_seq_unit.sv
// Directed self-checking bench for alu_seq_unit at N=8.
module tb_alu_seq_unit;

  logic clk = 1'b0;
  logic rst;
  int   pass_cnt  = 0;
  int   total_cnt = 0;

  always #5 clk = ~clk;

  alu_seq_unit_if #(.N(8), .DIGITS(2)) bus ();

  alu_seq_unit #(.N(8), .DIGITS(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  // Issue one op from IDLE; lat = negedges from accept until done is seen.
  task automatic run_op(input logic [2:0] sel, input logic [7:0] a, input logic [7:0] b,
                        input logic c, output int lat);
    @(negedge clk);
    bus.start = 1'b1; bus.select = sel; bus.A = a; bus.B = b; bus.cin = c;
    @(negedge clk);
    bus.start = 1'b0;
    lat = 1;
    while (bus.done !== 1'b1 && lat < 40) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; bus.start = 1'b1; bus.select = 3'd3; bus.A = 8'h11; bus.B = 8'h22; bus.cin = 1'b0;
    repeat (3) @(negedge clk);
    total_cnt++; if (bus.busy !== 1'b0) $display("FAIL rst_busy got %b want 0", bus.busy); else pass_cnt++;
    total_cnt++; if (bus.done !== 1'b0) $display("FAIL rst_done got %b want 0", bus.done); else pass_cnt++;
    total_cnt++; if (bus.result !== 8'h00) $display("FAIL rst_result got %h want 00", bus.result); else pass_cnt++;
    total_cnt++; if (bus.zero !== 1'b0) $display("FAIL rst_zero got %b want 0", bus.zero); else pass_cnt++;
    total_cnt++; if (bus.seg !== {7'h7E, 7'h7E}) $display("FAIL rst_seg got %h want %h", bus.seg, {7'h7E, 7'h7E}); else pass_cnt++;
    rst = 1'b0; bus.start = 1'b0;
  endtask

  task automatic test_add();
    int lat;
    run_op(3'd3, 8'h7F, 8'h01, 1'b0, lat);
    total_cnt++; if (lat !== 1) $display("FAIL add_lat got %0d want 1", lat); else pass_cnt++;
    total_cnt++; if (bus.result !== 8'h80) $display("FAIL add_result got %h want 80", bus.result); else pass_cnt++;
    total_cnt++; if (bus.overflow !== 1'b1) $display("FAIL add_ovf got %b want 1", bus.overflow); else pass_cnt++;
    total_cnt++; if (bus.negative !== 1'b1) $display("FAIL add_neg got %b want 1", bus.negative); else pass_cnt++;
    total_cnt++; if (bus.carry_flag !== 1'b0) $display("FAIL add_carry got %b want 0", bus.carry_flag); else pass_cnt++;
    total_cnt++; if (bus.busy !== 1'b1) $display("FAIL add_busy_done got %b want 1", bus.busy); else pass_cnt++;
    total_cnt++; if (bus.seg !== {7'h7F, 7'h7E}) $display("FAIL add_seg got %h want %h", bus.seg, {7'h7F, 7'h7E}); else pass_cnt++;
    @(negedge clk);
    total_cnt++; if (bus.done !== 1'b0 || bus.busy !== 1'b0) $display("FAIL add_after got done=%b busy=%b want 0 0", bus.done, bus.busy); else pass_cnt++;
    total_cnt++; if (bus.result !== 8'h80) $display("FAIL add_hold got %h want 80", bus.result); else pass_cnt++;
    run_op(3'd3, 8'hFF, 8'h01, 1'b1, lat);
    total_cnt++; if (bus.result !== 8'h01) $display("FAIL add_cin_result got %h want 01", bus.result); else pass_cnt++;
    total_cnt++; if ({bus.cout, bus.carry_flag, bus.overflow} !== 3'b110) $display("FAIL add_cin_flags got %b want 110", {bus.cout, bus.carry_flag, bus.overflow}); else pass_cnt++;
  endtask

  task automatic test_sub();
    int lat;
    run_op(3'd4, 8'h05, 8'h05, 1'b0, lat);
    total_cnt++; if (lat !== 1) $display("FAIL sub_lat got %0d want 1", lat); else pass_cnt++;
    total_cnt++; if (bus.result !== 8'h00) $display("FAIL sub_eq_result got %h want 00", bus.result); else pass_cnt++;
    total_cnt++; if (bus.zero !== 1'b1 || bus.carry_flag !== 1'b0) $display("FAIL sub_eq_flags got z=%b c=%b want 1 0", bus.zero, bus.carry_flag); else pass_cnt++;
    run_op(3'd4, 8'h03, 8'h05, 1'b0, lat);
    total_cnt++; if (bus.result !== 8'hFE) $display("FAIL sub_neg_result got %h want FE", bus.result); else pass_cnt++;
    total_cnt++; if ({bus.carry_flag, bus.cout, bus.negative, bus.overflow} !== 4'b1110) $display("FAIL sub_neg_flags got %b want 1110", {bus.carry_flag, bus.cout, bus.negative, bus.overflow}); else pass_cnt++;
    run_op(3'd4, 8'h80, 8'h01, 1'b0, lat);
    total_cnt++; if (bus.result !== 8'h7F || bus.overflow !== 1'b1) $display("FAIL sub_ovf got %h ovf=%b want 7F 1", bus.result, bus.overflow); else pass_cnt++;
    run_op(3'd4, 8'h00, 8'hFF, 1'b1, lat);
    total_cnt++; if (bus.result !== 8'h00 || bus.carry_flag !== 1'b1) $display("FAIL sub_bin got %h c=%b want 00 1", bus.result, bus.carry_flag); else pass_cnt++;
  endtask

  task automatic test_logic();
    int lat;
    run_op(3'd0, 8'hF0, 8'h3C, 1'b1, lat);
    total_cnt++; if (bus.result !== 8'h30) $display("FAIL and_result got %h want 30", bus.result); else pass_cnt++;
    total_cnt++; if ({bus.cout, bus.carry_flag, bus.overflow} !== 3'b000) $display("FAIL and_flags got %b want 000", {bus.cout, bus.carry_flag, bus.overflow}); else pass_cnt++;
    run_op(3'd1, 8'hF0, 8'h0C, 1'b0, lat);
    total_cnt++; if (bus.result !== 8'hFC || bus.negative !== 1'b1) $display("FAIL or_result got %h n=%b want FC 1", bus.result, bus.negative); else pass_cnt++;
    run_op(3'd2, 8'hAA, 8'hAA, 1'b0, lat);
    total_cnt++; if (bus.result !== 8'h00 || bus.zero !== 1'b1) $display("FAIL xor_result got %h z=%b want 00 1", bus.result, bus.zero); else pass_cnt++;
  endtask

  task automatic test_shift();
    int lat;
    @(negedge clk);
    bus.start = 1'b1; bus.select = 3'd5; bus.A = 8'h81; bus.B = 8'h03; bus.cin = 1'b0;
    @(negedge clk);
    // Competing request while shifting; must not be taken.
    bus.start = 1'b1; bus.select = 3'd7; bus.A = 8'hFF; bus.B = 8'hFF;
    total_cnt++; if (bus.busy !== 1'b1 || bus.done !== 1'b0) $display("FAIL shl_exec got busy=%b done=%b want 1 0", bus.busy, bus.done); else pass_cnt++;
    lat = 1;
    @(negedge clk);
    bus.start = 1'b0;
    lat = 2;
    while (bus.done !== 1'b1 && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    total_cnt++; if (lat !== 4) $display("FAIL shl_lat got %0d want 4", lat); else pass_cnt++;
    total_cnt++; if (bus.result !== 8'h08) $display("FAIL shl_result got %h want 08", bus.result); else pass_cnt++;
    @(negedge clk);
    total_cnt++; if (bus.busy !== 1'b0 || bus.result !== 8'h08) $display("FAIL shl_ignored got busy=%b res=%h want 0 08", bus.busy, bus.result); else pass_cnt++;
    run_op(3'd6, 8'h81, 8'h0A, 1'b0, lat);
    total_cnt++; if (lat !== 3 || bus.result !== 8'h20) $display("FAIL shr_mod got lat=%0d res=%h want 3 20", lat, bus.result); else pass_cnt++;
    run_op(3'd5, 8'h5A, 8'h08, 1'b0, lat);
    total_cnt++; if (lat !== 1 || bus.result !== 8'h5A) $display("FAIL shl_zero got lat=%0d res=%h want 1 5A", lat, bus.result); else pass_cnt++;
  endtask

  task automatic test_mul();
    int lat;
    run_op(3'd7, 8'h0F, 8'h11, 1'b0, lat);
    total_cnt++; if (lat !== 9) $display("FAIL mul_lat got %0d want 9", lat); else pass_cnt++;
    total_cnt++; if (bus.result !== 8'hFF) $display("FAIL mul_result got %h want FF", bus.result); else pass_cnt++;
    total_cnt++; if (bus.seg !== {7'h47, 7'h47}) $display("FAIL mul_seg got %h want %h", bus.seg, {7'h47, 7'h47}); else pass_cnt++;
    total_cnt++; if (bus.overflow !== 1'b0 || bus.negative !== 1'b1) $display("FAIL mul_flags got v=%b n=%b want 0 1", bus.overflow, bus.negative); else pass_cnt++;
    run_op(3'd7, 8'h10, 8'h10, 1'b0, lat);
    total_cnt++; if (lat !== 9 || bus.result !== 8'h00 || bus.zero !== 1'b1) $display("FAIL mul_wrap got lat=%0d res=%h z=%b want 9 00 1", lat, bus.result, bus.zero); else pass_cnt++;
  endtask

  task automatic test_reset_mid_exec();
    int lat;
    bit seen;
    run_op(3'd3, 8'h12, 8'h34, 1'b0, lat);
    total_cnt++; if (bus.result !== 8'h46) $display("FAIL pre_rst_add got %h want 46", bus.result); else pass_cnt++;
    @(negedge clk);
    bus.start = 1'b1; bus.select = 3'd7; bus.A = 8'h03; bus.B = 8'h05;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (3) @(negedge clk);
    total_cnt++; if (bus.busy !== 1'b1) $display("FAIL mul_exec4_busy got %b want 1", bus.busy); else pass_cnt++;
    rst = 1'b1;
    @(negedge clk);
    total_cnt++; if (bus.busy !== 1'b0 || bus.done !== 1'b0) $display("FAIL midrst_state got busy=%b done=%b want 0 0", bus.busy, bus.done); else pass_cnt++;
    total_cnt++; if (bus.result !== 8'h00 || bus.seg !== {7'h7E, 7'h7E}) $display("FAIL midrst_result got %h seg=%h want 00 %h", bus.result, bus.seg, {7'h7E, 7'h7E}); else pass_cnt++;
    rst = 1'b0;
    seen = 1'b0;
    repeat (12) begin
      @(negedge clk);
      if (bus.done === 1'b1) seen = 1'b1;
    end
    total_cnt++; if (seen !== 1'b0) $display("FAIL midrst_no_done got %b want 0", seen); else pass_cnt++;
    run_op(3'd3, 8'h01, 8'h02, 1'b0, lat);
    total_cnt++; if (lat !== 1 || bus.result !== 8'h03) $display("FAIL post_rst_add got lat=%0d res=%h want 1 03", lat, bus.result); else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    int lat;
    run_op(3'd3, 8'h01, 8'h01, 1'b0, lat);
    // Request raised during the DONE cycle; only the following IDLE takes it.
    bus.start = 1'b1; bus.select = 3'd2; bus.A = 8'hFF; bus.B = 8'h0F;
    @(negedge clk);
    total_cnt++; if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.result !== 8'h02) $display("FAIL b2b_done_ignored got busy=%b done=%b res=%h want 0 0 02", bus.busy, bus.done, bus.result); else pass_cnt++;
    @(negedge clk);
    bus.start = 1'b0;
    total_cnt++; if (bus.done !== 1'b1 || bus.result !== 8'hF0) $display("FAIL b2b_next got done=%b res=%h want 1 F0", bus.done, bus.result); else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_add();
    test_sub();
    test_logic();
    test_shift();
    test_mul();
    test_reset_mid_exec();
    test_back_to_back();
    repeat (2) @(negedge clk);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/alu_seq_unit.md
ALU_SEQ_UNIT -- requirements
Module: alu_seq_unit

Interface
REQ-001 Parameter N, default 8, operand/result width in bits; legal range 4..32, multiple of 4.
REQ-002 Parameter DIGITS, default N/4, number of seven-segment digits driven.
REQ-003 clk  input  1  single system clock; all state updates on its rising edge.
REQ-004 rst  input  1  synchronous, active-high reset, sampled on the rising edge of clk.
REQ-005 start  input  1  request; sampled only in IDLE.
REQ-006 A  input  N  operand A; latched on accepted start.
REQ-007 B  input  N  operand B; latched on accepted start.
REQ-008 select  input  3  opcode: 0 AND, 1 OR, 2 XOR, 3 ADD, 4 SUB, 5 SHL, 6 SHR (logical), 7 MUL; latched on accepted start.
REQ-009 cin  input  1  carry-in (ADD) / borrow-in (SUB); latched on accepted start.
REQ-010 busy  output  1  high whenever state is not IDLE.
REQ-011 done  output  1  one-cycle pulse when result and flags update.
REQ-012 result  output  N  registered result.
REQ-013 cout, carry_flag, overflow, negative, zero  output  1 each  registered flags.
REQ-014 seg  output  7*DIGITS  active-high segments; digit k at bits [7k+6:7k], bit order a..g MSB to LSB; digit k shows result[4k+3:4k] in hex.

Function
REQ-015 FSM states IDLE, EXEC, DONE; IDLE plus start goes to DONE for ops 0-4, to EXEC for ops 5-7 with a nonzero step count, otherwise to DONE.
REQ-016 Ops 0-4: result written on the accept edge; done high the following cycle (latency 1).
REQ-017 SHL/SHR: shift amount s = B mod N; one bit per EXEC cycle; done s+1 cycles after the accept edge; s=0 behaves as a single-cycle op returning A.
REQ-018 MUL: shift-add, one partial product per EXEC cycle, N EXEC cycles; result = low N bits of A*B (unsigned); done N+1 cycles after the accept edge.
REQ-019 DONE lasts exactly one cycle, asserts done, then returns to IDLE; a start in that same cycle is ignored.
REQ-020 start while busy is ignored; operands and opcode are not re-sampled.
REQ-021 ADD: {cout,result} = A+B+cin; carry_flag = cout; overflow = signed two's-complement overflow.
REQ-022 SUB: result = A-B-cin; cout = carry_flag = borrow-out (1 when A < B+cin, unsigned); overflow = signed overflow.
REQ-023 Logic, shift and MUL ops: cout, carry_flag, overflow forced 0; MUL high bits discarded without a flag.
REQ-024 negative = result[N-1]; zero = (result == 0); both are valid for every op.
REQ-025 result and all flags change only on the cycle that enters DONE and hold until the next completed op; busy drops together with done's falling edge.
REQ-026 seg is a combinational decode of the registered result, so it updates in the same cycle as result.

Reset
REQ-027 rst high: state IDLE; result, all flags, busy, done, and the step counter cleared to 0; seg shows all digits as "0".
REQ-028 rst mid-EXEC aborts the op; no done pulse is produced for it; rst has priority over start.

Structure
REQ-029 Shared package alu_pkg holds the opcode enum (OP_AND..OP_MUL) and the FSM state enum.
REQ-030 One sub-module, hex_to_seg (4-bit in, 7-bit out), instantiated DIGITS times via generate.
REQ-031 All flag logic is registered; no latches; every combinational always block assigns all of its outputs.

Verification (N=8)
REQ-032 ADD A=0x7F B=0x01 cin=0 -> done 1 cycle after accept, result 0x80, overflow=1, negative=1, carry_flag=0, seg digits "8","0".
REQ-033 SUB A=0x05 B=0x05 cin=0 -> result 0x00, zero=1, carry_flag=0; SUB A=0x03 B=0x05 -> result 0xFE, carry_flag=1, negative=1.
REQ-034 SHL A=0x81 B=0x03 -> busy for 3 EXEC cycles, done 4 cycles after accept, result 0x08; a start pulsed mid-shift with new operands is ignored.
REQ-035 MUL A=0x0F B=0x11 -> done 9 cycles after accept, result 0xFF, seg "F","F", overflow=0; MUL A=0x10 B=0x10 -> result 0x00, zero=1.
REQ-036 rst asserted at the 4th EXEC cycle of a MUL -> next cycle state IDLE, busy=0, result=0, no done pulse; a fresh ADD then completes normally.
